instruction_fetch_ctrl: RTL and testbench

//  Sequences the instruction memory. It owns the PC, streams program words into the memory

---
 rtl/riscv_pkg.sv | 7 +
 rtl/fetch_pc_unit.sv | 24 ++
 rtl/instruction_fetch_ctrl.sv | 87 ++++++++
 tb/tb_instruction_fetch_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared fetch-controller types and constants
package riscv_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] HALT_WORD = '0;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);
  typedef enum logic [1:0] {IDLE, LOAD, FETCH, HALT} fetch_state_t;
endpackage

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: pc register, next-pc selection and memory range check
module fetch_pc_unit import riscv_pkg::*; #(
  parameter int AW = 5
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            en,
  input  logic            clr,
  input  logic            advance,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] pc,
  output logic [AW-1:0]   fetch_addr,
  output logic            oor
);
  logic [XLEN-1:0] next_pc;
  assign next_pc = redirect ? redirect_pc & ~XLEN'(3) : advance ? pc + PC_STEP : pc;
  assign fetch_addr = next_pc[AW+1:2];
  assign oor = |pc[XLEN-1:AW+2];
  always_ff @(posedge clock or posedge reset)
    if (reset) pc <= '0;
    else if (clr) pc <= '0;
    else if (en) pc <= next_pc;
endmodule

// File: rtl/instruction_fetch_ctrl.sv
// instruction_fetch_ctrl: loads program memory, then streams instructions to decode
module instruction_fetch_ctrl import riscv_pkg::*; #(
  parameter int DEPTH = 32,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            load_start,
  input  logic            load_valid,
  input  logic [XLEN-1:0] load_data,
  input  logic            load_last,
  output logic            load_ready,
  output logic            load_err,
  input  logic            run,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            id_ready,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  output logic            instr_valid,
  output logic            halted,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata
);
  fetch_state_t state;
  logic [AW-1:0] ptr, fetch_addr;
  logic vld, fetching, load_acc, load_done, at_end, halt_hit, oor;
  assign fetching = state == FETCH;
  assign load_acc = state == LOAD && load_valid;
  assign at_end = ptr == AW'(DEPTH - 1);
  assign load_done = load_acc && (load_last || at_end);
  // a halt word or out-of-range pc is never handed to decode
  assign halt_hit = fetching && (oor || (vld && mem_rdata == HALT_WORD));
  assign instr_valid = fetching && vld && !halt_hit;
  assign instr = mem_rdata;
  assign halted = state == HALT;
  assign load_ready = state == LOAD;
  assign mem_we = load_acc;
  assign mem_wdata = load_data;
  assign mem_addr = fetching ? fetch_addr : load_acc ? ptr : '0;
  fetch_pc_unit #(.AW(AW)) u_pc (
    .clock(clock),
    .reset(reset),
    .en(fetching),
    .clr(load_done),
    .advance(instr_valid && id_ready),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .pc(instr_pc),
    .fetch_addr(fetch_addr),
    .oor(oor)
  );
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= IDLE;
      ptr <= '0;
      vld <= 1'b0;
      load_err <= 1'b0;
    end else
      case (state)
        IDLE: if (load_start) begin
          state <= LOAD;
          ptr <= '0;
          load_err <= 1'b0;
        end else if (run) begin
          state <= FETCH;
          vld <= 1'b0;
        end
        LOAD: if (load_acc) begin
          ptr <= ptr + 1'b1;
          if (at_end && !load_last) load_err <= 1'b1;
          if (load_done) state <= IDLE;
        end
        FETCH: if (halt_hit && !redirect) begin
          state <= HALT;
          vld <= 1'b0;
        end else vld <= 1'b1;
        HALT: if (load_start) begin
          state <= LOAD;
          ptr <= '0;
          load_err <= 1'b0;
        end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_instruction_fetch_ctrl.sv
// tb_instruction_fetch_ctrl: randomized scoreboard bench with a program-level fetch model
module tb_instruction_fetch_ctrl;
  import riscv_pkg::*;
  localparam int DEPTH = 32;
  localparam int AW = 5;
  typedef struct {logic [31:0] a; logic [31:0] d;} pair_t;
  logic clock = 0, reset = 1, load_start = 0, load_valid = 0, load_last = 0;
  logic run = 0, redirect = 0, id_ready = 0;
  logic [31:0] load_data = 0, redirect_pc = 0, mem_rdata, instr, instr_pc, mem_wdata;
  logic load_ready, load_err, instr_valid, halted, mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0] mem [DEPTH];
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] prog [40];
  bit pflag [16];
  logic [31:0] ptgt [16];
  int plan_n = 0;
  pair_t wq[$], fq[$];
  int tests = 0, fails = 0;
  logic prev_stall = 0;
  logic [31:0] prev_pc = 0, prev_instr = 0;
  int cyc;
  instruction_fetch_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clock(clock), .reset(reset), .load_start(load_start), .load_valid(load_valid),
    .load_data(load_data), .load_last(load_last), .load_ready(load_ready), .load_err(load_err),
    .run(run), .redirect(redirect), .redirect_pc(redirect_pc), .id_ready(id_ready),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .halted(halted),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );
  always #5 clock = ~clock;
  always @(posedge clock) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  // scoreboard monitor: memory writes, accepted instructions, stall stability
  always @(negedge clock) begin
    if (reset) prev_stall <= 0;
    else begin
      if (mem_we) begin
        if (wq.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_write: got addr %h data %h expected no write", mem_addr, mem_wdata);
        end else begin
          check("mem_addr", 32'(mem_addr), wq[0].a);
          check("mem_wdata", mem_wdata, wq[0].d);
          void'(wq.pop_front());
        end
      end
      if (instr_valid && id_ready) begin
        if (fq.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_instr: got pc %h instr %h expected none", instr_pc, instr);
        end else begin
          check("instr_pc", instr_pc, fq[0].a);
          check("instr", instr, fq[0].d);
          void'(fq.pop_front());
        end
      end
      if (prev_stall) begin
        check("stall_valid", 32'(instr_valid), 1);
        check("stall_pc", instr_pc, prev_pc);
        check("stall_instr", instr, prev_instr);
      end
      prev_stall <= instr_valid && !id_ready && !redirect;
      prev_pc <= instr_pc;
      prev_instr <= instr;
    end
  end
  // program-level model: walk the loaded image, following the redirect plan
  task automatic gen_expect();
    logic [31:0] pc = 0;
    int k = 0;
    fq.delete();
    for (int n = 0; n < 200; n++) begin
      if (pc >= DEPTH * 4 || ref_mem[pc / 4] == 0) break;
      fq.push_back('{pc, ref_mem[pc / 4]});
      pc = (k < plan_n && pflag[k]) ? ptgt[k] - ptgt[k] % 4 : pc + 4;
      k++;
    end
  endtask
  task automatic load_prog(input int n, input bit last);
    int i = 0;
    load_start = 1;
    @(posedge clock); #1 load_start = 0;
    check("load_err_clr", 32'(load_err), 0);
    check("load_ready", 32'(load_ready), 1);
    while (i < n) begin
      load_valid = ($urandom % 4 != 0);
      load_data = $urandom;
      load_last = 0;
      run = (i < DEPTH) ? 1'($urandom % 2) : 1'b0;
      redirect = 1'($urandom % 2);
      if (load_valid) begin
        load_data = prog[i];
        load_last = last && i == n - 1;
        if (i < DEPTH) begin
          wq.push_back('{i, prog[i]});
          ref_mem[i] = prog[i];
        end
        i++;
      end
      @(posedge clock); #1;
    end
    load_valid = 0; load_last = 0; run = 0; redirect = 0;
    check("load_exit", 32'(load_ready), 0);
    check("write_drain", wq.size(), 0);
  endtask
  task automatic fetch_run(input bit rnd, output int c);
    int k = 0;
    c = 0;
    run = 1;
    @(posedge clock); #1 run = 0;
    while (!halted && c < 400) begin
      c++;
      id_ready = rnd ? ($urandom % 4 != 0) : 1'b1;
      redirect = 0;
      redirect_pc = $urandom;
      if (instr_valid && id_ready) begin
        if (k < plan_n && pflag[k]) begin
          redirect = 1;
          redirect_pc = ptgt[k];
        end
        k++;
      end
      @(posedge clock); #1;
    end
    id_ready = 0; redirect = 0;
    check("halt_reached", 32'(halted), 1);
    check("halt_no_valid", 32'(instr_valid), 0);
    check("fetch_drain", fq.size(), 0);
  endtask
  initial begin
    repeat (2) @(posedge clock);
    #1;
    check("rst_instr_valid", 32'(instr_valid), 0);
    check("rst_halted", 32'(halted), 0);
    check("rst_load_err", 32'(load_err), 0);
    check("rst_load_ready", 32'(load_ready), 0);
    check("rst_mem_we", 32'(mem_we), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    reset = 0;
    @(posedge clock); #1;
    for (int i = 0; i < 33; i++) prog[i] = $urandom | 32'h1;
    load_prog(33, 0);
    check("load_err_set", 32'(load_err), 1);
    prog[0] = 32'h00000033; prog[1] = 32'h00100093; prog[2] = 32'h00208113; prog[3] = 32'h0;
    load_prog(4, 1);
    plan_n = 0;
    gen_expect();
    fetch_run(0, cyc);
    check("no_bubble_cycles", cyc, 5);
    run = 1;
    @(posedge clock); #1 run = 0;
    check("run_in_halt", 32'(halted), 1);
    reset = 1;
    @(posedge clock); #1 reset = 0;
    gen_expect();
    run = 1;
    @(posedge clock); #1 run = 0;
    id_ready = 1;
    for (int c = 0; c < 20 && !(instr_valid && instr_pc == 8); c++) begin
      @(posedge clock); #1;
    end
    check("reach_pc8", instr_pc, 8);
    reset = 1;
    #1;
    check("midrst_valid", 32'(instr_valid), 0);
    check("midrst_pc", instr_pc, 0);
    check("midrst_halted", 32'(halted), 0);
    fq.delete();
    @(posedge clock); #1 reset = 0; id_ready = 0;
    @(posedge clock); #1;
    check("post_rst_idle", 32'(load_ready | instr_valid | halted), 0);
    for (int s = 0; s < 8; s++) begin
      int n = $urandom_range(4, 32);
      for (int i = 0; i < n; i++) prog[i] = ($urandom % 8 == 0) ? 32'h0 : ($urandom | 32'h1);
      load_prog(n, 1);
      plan_n = $urandom_range(0, 16);
      for (int k = 0; k < plan_n; k++) begin
        pflag[k] = ($urandom % 3 == 0);
        ptgt[k] = $urandom_range(0, DEPTH * 4 + 15);
      end
      gen_expect();
      fetch_run(1, cyc);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
